// File: rtl/cv_sprite_linebuf.sv
// cv_sprite_linebuf -- double-banked sprite line buffer.
//
// Two banks of LANES independent line RAMs (2^ADDR_W x PIX_W each). The
// sprite side composes into bank bank_sel with a per-lane two-stage
// read-modify-write where the first opaque writer wins. The display side
// reads the other bank and clears each location it reads. A line_swap
// exchanges the banks once the sprite pipeline is empty.
//
// Ports:
//   clk         single clock, rising edge
//   reset_n     asynchronous active-low reset
//   line_swap   one-cycle bank exchange request
//   sp_wen      per-lane sprite write request
//   sp_addr     per-lane write address, lane k at [k*ADDR_W +: ADDR_W]
//   sp_wrdata   per-lane pixel, lane k at [k*PIX_W +: PIX_W]; MSB = transparent
//   pix_ren     display read request
//   pix_rdaddr  display read address (all lanes)
//   pixdata     display data, valid the cycle after pix_ren
//   pix_valid   pixdata qualifier
//   bank_sel    bank currently owned by the sprite side
//   busy        init sweep running or swap pending
//   collision   sticky opaque-on-opaque flag, cleared by a swap
module cv_sprite_linebuf #(
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 10,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      line_swap,
  input  logic [LANES-1:0]          sp_wen,
  input  logic [LANES*ADDR_W-1:0]   sp_addr,
  input  logic [LANES*PIX_W-1:0]    sp_wrdata,
  input  logic                      pix_ren,
  input  logic [ADDR_W-1:0]         pix_rdaddr,
  output logic [LANES*PIX_W-1:0]    pixdata,
  output logic                      pix_valid,
  output logic                      bank_sel,
  output logic                      busy,
  output logic                      collision
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PIX_W-1:0] CLEAR = {1'b1, {(PIX_W-1){1'b0}}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   init_cnt, init_cnt_nxt;
  logic                run;

  logic                swap_pend;
  logic                swap_go;
  logic                clr_pend;
  logic [ADDR_W-1:0]   clr_addr;
  logic                clr_bank;

  logic [LANES-1:0]        s0_go_v;
  logic [LANES-1:0]        s1_valid_v;
  logic [LANES-1:0]        coll_v;
  logic [LANES*PIX_W-1:0]  rd_word;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      ST_INIT: begin
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == {ADDR_W{1'b1}}) begin
          state_nxt    = ST_RUN;
          init_cnt_nxt = '0;
        end
      end
      ST_RUN: ;
      default: state_nxt = ST_INIT;
    endcase
  end

  assign run  = (state == ST_RUN);
  assign busy = (state == ST_INIT) | swap_pend;

  // A swap may only land when no lane has a write in either stage, so the
  // sprite bank never changes under a read-modify-write in flight.
  assign swap_go = run & (line_swap | swap_pend) & ~(|s1_valid_v) & ~(|s0_go_v);

  // ------------------------------------------------- control / display side
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_sel  <= 1'b0;
      swap_pend <= 1'b0;
      collision <= 1'b0;
      pix_valid <= 1'b0;
      pixdata   <= '0;
      clr_pend  <= 1'b0;
      clr_addr  <= '0;
      clr_bank  <= 1'b0;
    end else begin
      if (swap_go) begin
        bank_sel  <= ~bank_sel;
        swap_pend <= 1'b0;
        collision <= 1'b0;
      end else begin
        if (line_swap) swap_pend <= 1'b1;
        if (|coll_v)   collision <= 1'b1;
      end
      pix_valid <= run & pix_ren;
      if (run && pix_ren) pixdata <= rd_word;
      // The clear remembers its bank so a swap between read and clear
      // still clears the location that was actually read.
      clr_pend <= run & pix_ren;
      clr_addr <= pix_rdaddr;
      clr_bank <= ~bank_sel;
    end
  end

  // ------------------------------------------------------------ lanes
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [PIX_W-1:0]  ram [2][DEPTH];
    logic [ADDR_W-1:0] wa;
    logic [PIX_W-1:0]  wd;
    logic              go;
    logic [PIX_W-1:0]  exist_rd;
    logic [PIX_W-1:0]  disp_rd;
    logic              s1_v;
    logic [ADDR_W-1:0] s1_addr;
    logic [PIX_W-1:0]  s1_data;
    logic [PIX_W-1:0]  s1_exist;
    logic              s1_we;

    assign wa = sp_addr[k*ADDR_W +: ADDR_W];
    assign wd = sp_wrdata[k*PIX_W +: PIX_W];
    assign go = run & ~swap_pend & sp_wen[k];

    assign s1_we     = s1_v & s1_exist[PIX_W-1] & ~s1_data[PIX_W-1];
    assign coll_v[k] = s1_v & ~s1_exist[PIX_W-1] & ~s1_data[PIX_W-1];
    assign s0_go_v[k]    = go;
    assign s1_valid_v[k] = s1_v;

    // Existing pixel for S0: forward any same-cycle write to the same
    // location so back-to-back operations behave as if serial.
    always_comb begin
      exist_rd = ram[bank_sel][wa];
      if (s1_we && (s1_addr == wa))
        exist_rd = s1_data;
      else if (clr_pend && (clr_bank == bank_sel) && (clr_addr == wa))
        exist_rd = CLEAR;
    end

    always_comb begin
      disp_rd = ram[~bank_sel][pix_rdaddr];
      if (clr_pend && (clr_bank == ~bank_sel) && (clr_addr == pix_rdaddr))
        disp_rd = CLEAR;
    end
    assign rd_word[k*PIX_W +: PIX_W] = disp_rd;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_v     <= 1'b0;
        s1_addr  <= '0;
        s1_data  <= '0;
        s1_exist <= '0;
      end else begin
        s1_v <= go;
        if (go) begin
          s1_addr  <= wa;
          s1_data  <= wd;
          s1_exist <= exist_rd;
        end
      end
    end

    // Sprite writes and display clears always target different banks
    // (a swap needs an empty sprite pipeline), so the write port is never
    // shared in one cycle.
    always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
        ram[0][init_cnt] <= CLEAR;
        ram[1][init_cnt] <= CLEAR;
      end else begin
        if (s1_we)    ram[bank_sel][s1_addr] <= s1_data;
        if (clr_pend) ram[clr_bank][clr_addr] <= CLEAR;
      end
    end
  end

endmodule

// File: tb/tb_cv_sprite_linebuf.sv
// Self-checking bench for cv_sprite_linebuf (PIX_W=16, ADDR_W=4, LANES=4).
// Reference model: two banks of plain arrays updated at transaction level.
module tb_cv_sprite_linebuf;
  localparam int PIX_W  = 16;
  localparam int ADDR_W = 4;
  localparam int LANES  = 4;
  localparam int DEPTH  = 16;
  localparam int W      = LANES*PIX_W;
  localparam logic [15:0] CLR = 16'h8000;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    line_swap;
  logic [LANES-1:0]        sp_wen;
  logic [LANES*ADDR_W-1:0] sp_addr;
  logic [LANES*PIX_W-1:0]  sp_wrdata;
  logic                    pix_ren;
  logic [ADDR_W-1:0]       pix_rdaddr;
  logic [W-1:0]            pixdata;
  logic                    pix_valid;
  logic                    bank_sel;
  logic                    busy;
  logic                    collision;

  always #5 clk = ~clk;

  cv_sprite_linebuf #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk(clk), .reset_n(reset_n), .line_swap(line_swap), .sp_wen(sp_wen),
    .sp_addr(sp_addr), .sp_wrdata(sp_wrdata), .pix_ren(pix_ren),
    .pix_rdaddr(pix_rdaddr), .pixdata(pixdata), .pix_valid(pix_valid),
    .bank_sel(bank_sel), .busy(busy), .collision(collision)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------- reference model
  logic [15:0] m_mem [2][LANES][DEPTH];
  logic        m_bank;
  logic        m_coll;

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < LANES; l++)
        for (int a = 0; a < DEPTH; a++) m_mem[b][l][a] = CLR;
    m_bank = 1'b0;
    m_coll = 1'b0;
  endtask

  // First opaque pixel at a location wins; a later opaque one only flags.
  task automatic model_write(input int l, input int a, input logic [15:0] d);
    if (!d[15]) begin
      if (m_mem[m_bank][l][a][15]) m_mem[m_bank][l][a] = d;
      else m_coll = 1'b1;
    end
  endtask

  task automatic model_read(input int a, output logic [W-1:0] e);
    for (int l = 0; l < LANES; l++) begin
      e[l*PIX_W +: PIX_W] = m_mem[!m_bank][l][a];
      m_mem[!m_bank][l][a] = CLR;
    end
  endtask

  // ---------------------------------------------------- stimulus helpers
  task automatic idle();
    sp_wen = '0; pix_ren = 1'b0; line_swap = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input int a);
    logic [W-1:0] e;
    pix_ren = 1'b1;
    pix_rdaddr = a[ADDR_W-1:0];
    model_read(a, e);
    @(negedge clk);
    check_eq("rd_valid", {63'd0, pix_valid}, 64'd1);
    check_eq("rd_data", pixdata, e);
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a++) do_read(a);
    idle();
    check_eq("valid_low", {63'd0, pix_valid}, 64'd0);
  endtask

  task automatic wr1(input int l, input int a, input logic [15:0] d);
    sp_wen = '0; pix_ren = 1'b0; line_swap = 1'b0;
    sp_wen[l] = 1'b1;
    sp_addr[l*ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
    sp_wrdata[l*PIX_W +: PIX_W] = d;
    model_write(l, a, d);
    @(negedge clk);
  endtask

  // Drain pipeline, check collision, swap with an idle pipeline.
  task automatic do_swap();
    logic old;
    idle();
    check_eq("coll_pre_swap", {63'd0, collision}, {63'd0, m_coll});
    old = bank_sel;
    line_swap = 1'b1;
    @(negedge clk);
    line_swap = 1'b0;
    m_bank = !m_bank;
    m_coll = 1'b0;
    check_eq("bank_toggle", {63'd0, bank_sel}, {63'd0, !old});
    check_eq("busy_after_swap", {63'd0, busy}, 64'd0);
    check_eq("coll_cleared", {63'd0, collision}, 64'd0);
  endtask

  task automatic rand_cycle();
    logic [W-1:0] e;
    bit rd;
    for (int l = 0; l < LANES; l++) begin
      logic [15:0] d;
      int a;
      sp_wen[l] = ($urandom_range(0, 1) == 1);
      a = $urandom_range(0, 3);
      d = 16'($urandom);
      d[15] = ($urandom_range(0, 3) == 0);
      sp_addr[l*ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
      sp_wrdata[l*PIX_W +: PIX_W] = d;
      if (sp_wen[l]) model_write(l, a, d);
    end
    rd = ($urandom_range(0, 2) == 0);
    pix_ren = rd;
    line_swap = 1'b0;
    if (rd) begin
      int a = $urandom_range(0, 7);
      pix_rdaddr = a[ADDR_W-1:0];
      model_read(a, e);
    end
    @(negedge clk);
    if (rd) check_eq("rand_rd_data", pixdata, e);
    check_eq("rand_rd_valid", {63'd0, pix_valid}, {63'd0, rd});
  endtask

  task automatic wait_init();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("init_cycles", 64'(n), 64'd16);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_pixdata", pixdata, '0);
    check_eq("rst_valid", {63'd0, pix_valid}, 64'd0);
    check_eq("rst_bank", {63'd0, bank_sel}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd1);
    check_eq("rst_coll", {63'd0, collision}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic old;
    reset_n = 1'b0; line_swap = 1'b0; sp_wen = '0; sp_addr = '0;
    sp_wrdata = '0; pix_ren = 1'b0; pix_rdaddr = '0;
    #1;
    check_reset_outputs();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    wait_init();
    model_reset();

    // Every address of both banks reads as clear after the sweep.
    sweep();
    do_swap();
    sweep();

    // Transparent data is never written and raises no collision.
    wr1(1, 2, 16'h8ABC);
    do_swap();
    sweep();

    // Back-to-back opaque writes to one location: first wins, collision.
    wr1(0, 5, 16'h0123);
    wr1(0, 5, 16'h0456);
    do_swap();
    sweep();

    // Repeat read of one address returns the clear value the second time.
    wr1(2, 7, 16'h0777);
    do_swap();
    do_read(7);
    do_read(7);
    idle();

    // Randomized lines.
    for (int it = 0; it < 6; it++) begin
      repeat (30) rand_cycle();
      do_swap();
      sweep();
    end

    // Swap requested alongside a write: held pending until S1 drains.
    wr1(0, 9, 16'h0111);
    wr1(0, 9, 16'h0222);
    idle();
    check_eq("coll_set", {63'd0, collision}, 64'd1);
    old = bank_sel;
    sp_wen = 4'b0001;
    sp_addr[0 +: ADDR_W] = 4'd11;
    sp_wrdata[0 +: PIX_W] = 16'h0333;
    line_swap = 1'b1;
    model_write(0, 11, 16'h0333);
    @(negedge clk);
    check_eq("pend_busy1", {63'd0, busy}, 64'd1);
    check_eq("pend_bank1", {63'd0, bank_sel}, {63'd0, old});
    sp_addr[0 +: ADDR_W] = 4'd10;
    sp_wrdata[0 +: PIX_W] = 16'h0444;
    line_swap = 1'b1;
    @(negedge clk);
    check_eq("pend_busy2", {63'd0, busy}, 64'd1);
    check_eq("pend_bank2", {63'd0, bank_sel}, {63'd0, old});
    sp_wen = '0; line_swap = 1'b0;
    @(negedge clk);
    m_bank = !m_bank;
    m_coll = 1'b0;
    check_eq("pend_bank_tgl", {63'd0, bank_sel}, {63'd0, !old});
    check_eq("pend_busy_clr", {63'd0, busy}, 64'd0);
    check_eq("pend_coll_clr", {63'd0, collision}, 64'd0);
    idle();
    check_eq("single_toggle", {63'd0, bank_sel}, {63'd0, !old});
    sweep();

    // Reset in mid-line: immediate reset outputs, INIT repeats, data gone.
    repeat (8) rand_cycle();
    sp_wen = 4'b1111; pix_ren = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    sp_wen = '0; pix_ren = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_init();
    model_reset();
    sweep();
    do_swap();
    sweep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
